reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/p1v_reset_pkg.sv | 29 ++
 rtl/reset_sequencer_if.sv | 26 ++
 rtl/p1v_debounce.sv | 53 +++++
 rtl/reset_sequencer.sv | 124 ++++++++++++
 tb/tb_reset_sequencer.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/p1v_reset_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | p1v_reset_pkg : shared sequencer state and reset-cause encodings            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package p1v_reset_pkg;

  typedef enum logic [1:0] {
    S_LOCK = 2'd0,
    S_HOLD = 2'd1,
    S_RUN  = 2'd2
  } seq_state_e;

  typedef enum logic [1:0] {
    CAUSE_POR  = 2'b00,
    CAUSE_PLL  = 2'b01,
    CAUSE_TACT = 2'b10,
    CAUSE_PLUG = 2'b11
  } reset_cause_e;

  localparam logic [7:0] COUNT_MAX = 8'd255;

  // Plug outranks the tactile switch when both fire together.
  function automatic reset_cause_e source_cause(input logic plug_req);
    return plug_req ? CAUSE_PLUG : CAUSE_TACT;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reset_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reset_sequencer_if : reset sources in, Propeller reset and status out       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface reset_sequencer_if;

  logic       pll_locked;
  logic       tact_n;
  logic       plug_resn;
  logic       resn;
  logic [1:0] reset_cause;
  logic [7:0] reset_count;

  modport master (
    output pll_locked, tact_n, plug_resn,
    input  resn, reset_cause, reset_count
  );

  modport slave (
    input  pll_locked, tact_n, plug_resn,
    output resn, reset_cause, reset_count
  );

endinterface
`default_nettype wire

// File: rtl/p1v_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | p1v_debounce : 2-flop synchronizer followed by a stable-count filter        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module p1v_debounce #(
  parameter int   STABLE_CYCLES = 16,
  parameter logic RESET_VALUE   = 1'b1
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic din,
  output logic      dout
);

  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The output flips on the STABLE_CYCLES-th consecutive sample that disagrees.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    if (sync2_q != state_q) begin
      if (cnt_q == CNT_LAST) begin
        state_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= RESET_VALUE;
      sync2_q <= RESET_VALUE;
      state_q <= RESET_VALUE;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout = state_q;

endmodule
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reset_sequencer : PLL / switch / plug driven reset for the Propeller core   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module reset_sequencer
  import p1v_reset_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1600000,
  parameter int PLUG_MIN_CYCLES = 16,
  parameter int HOLD_CYCLES     = 16000
) (
  input wire logic          clock_160,
  input wire logic          reset,
  reset_sequencer_if.slave  bus
);

  localparam int              HOLD_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);

  logic pll_s1_q, pll_s2_q;
  logic tact_db, plug_db;
  logic tact_pressed, plug_req, any_src;

  seq_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  reset_cause_e      cause_q, cause_d;
  logic [7:0]        count_q, count_d;
  logic              resn_q;

  p1v_debounce #(
    .STABLE_CYCLES (DEBOUNCE_CYCLES),
    .RESET_VALUE   (1'b1)
  ) u_tact_db (
    .clk  (clock_160),
    .rst  (reset),
    .din  (bus.tact_n),
    .dout (tact_db)
  );

  p1v_debounce #(
    .STABLE_CYCLES (PLUG_MIN_CYCLES),
    .RESET_VALUE   (1'b1)
  ) u_plug_db (
    .clk  (clock_160),
    .rst  (reset),
    .din  (bus.plug_resn),
    .dout (plug_db)
  );

  assign tact_pressed = ~tact_db;
  assign plug_req     = ~plug_db;
  assign any_src      = tact_pressed | plug_req;

  // Lock loss is tested first in every state so it wins over source requests.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cause_d = cause_q;
    count_d = count_q;
    case (state_q)
      S_LOCK: begin
        if (pll_s2_q) begin
          state_d = S_HOLD;
          hold_d  = HOLD_LOAD;
        end
      end
      S_HOLD: begin
        if (!pll_s2_q) begin
          state_d = S_LOCK;
          cause_d = CAUSE_PLL;
        end else if (any_src) begin
          hold_d = HOLD_LOAD;
        end else if (hold_q == '0) begin
          state_d = S_RUN;
          if (count_q != COUNT_MAX) begin
            count_d = count_q + 8'd1;
          end
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      S_RUN: begin
        if (!pll_s2_q) begin
          state_d = S_LOCK;
          cause_d = CAUSE_PLL;
        end else if (any_src) begin
          state_d = S_HOLD;
          hold_d  = HOLD_LOAD;
          cause_d = source_cause(plug_req);
        end
      end
      default: begin
        state_d = S_LOCK;
      end
    endcase
  end

  always_ff @(posedge clock_160) begin
    if (reset) begin
      pll_s1_q <= 1'b1;
      pll_s2_q <= 1'b1;
      state_q  <= S_LOCK;
      hold_q   <= '0;
      cause_q  <= CAUSE_POR;
      count_q  <= '0;
      resn_q   <= 1'b0;
    end else begin
      pll_s1_q <= bus.pll_locked;
      pll_s2_q <= pll_s1_q;
      state_q  <= state_d;
      hold_q   <= hold_d;
      cause_q  <= cause_d;
      count_q  <= count_d;
      resn_q   <= (state_d == S_RUN);
    end
  end

  assign bus.resn        = resn_q;
  assign bus.reset_cause = cause_q;
  assign bus.reset_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_reset_sequencer : directed and random stimulus against a reference model |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_reset_sequencer;

  localparam int DB = 8;
  localparam int PM = 2;
  localparam int HC = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reset_sequencer_if sif ();

  reset_sequencer #(
    .DEBOUNCE_CYCLES (DB),
    .PLUG_MIN_CYCLES (PM),
    .HOLD_CYCLES     (HC)
  ) dut (
    .clock_160 (clk),
    .reset     (rst),
    .bus       (sif)
  );

  int n_checks = 0;
  int n_fail   = 0;

  bit rst_in  = 1'b1;
  bit pll_in  = 1'b1;
  bit tact_in = 1'b1;
  bit plug_in = 1'b1;

  // Reference model: delay lines, run-length filters, quiet-cycle counting.
  bit pll_dl[$];
  bit tact_dl[$];
  bit plug_dl[$];
  bit tact_db, plug_db, tact_prev, plug_prev;
  int tact_run, plug_run;
  bit m_locked_wait;
  bit m_running;
  int m_quiet;
  int m_cause;
  int m_count;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    pll_dl  = '{1'b1, 1'b1};
    tact_dl = '{1'b1, 1'b1};
    plug_dl = '{1'b1, 1'b1};
    tact_db = 1'b1; plug_db = 1'b1;
    tact_prev = 1'b1; plug_prev = 1'b1;
    tact_run = 0; plug_run = 0;
    m_locked_wait = 1'b1;
    m_running = 1'b0;
    m_quiet = 0;
    m_cause = 0;
    m_count = 0;
  endtask

  // A filtered level follows the sample once n identical samples in a row disagree with it.
  task automatic filt(input bit s, input int n, inout bit db, inout int run, inout bit prev);
    if (s == prev) run++;
    else run = 1;
    prev = s;
    if (s != db && run >= n) db = s;
  endtask

  task automatic model_edge();
    bit ps, ts, pls, src_t, src_p;
    if (rst_in) begin
      model_reset();
      return;
    end
    ps  = pll_dl.pop_front();  pll_dl.push_back(pll_in);
    ts  = tact_dl.pop_front(); tact_dl.push_back(tact_in);
    pls = plug_dl.pop_front(); plug_dl.push_back(plug_in);
    src_t = !tact_db;
    src_p = !plug_db;
    if (m_locked_wait) begin
      if (ps) begin
        m_locked_wait = 1'b0;
        m_quiet = 0;
      end
    end else if (!ps) begin
      m_locked_wait = 1'b1;
      m_running = 1'b0;
      m_cause = 1;
    end else if (m_running) begin
      if (src_t || src_p) begin
        m_running = 1'b0;
        m_quiet = 0;
        m_cause = src_p ? 3 : 2;
      end
    end else if (src_t || src_p) begin
      m_quiet = 0;
    end else begin
      m_quiet++;
      if (m_quiet == HC + 1) begin
        m_running = 1'b1;
        if (m_count < 255) m_count++;
      end
    end
    filt(ts, DB, tact_db, tact_run, tact_prev);
    filt(pls, PM, plug_db, plug_run, plug_prev);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = rst_in;
      sif.pll_locked = pll_in;
      sif.tact_n = tact_in;
      sif.plug_resn = plug_in;
      @(posedge clk);
      model_edge();
      #1;
      chk("resn", {31'd0, sif.resn}, {31'd0, m_running});
      chk("cause", {30'd0, sif.reset_cause}, m_cause);
      chk("count", {24'd0, sif.reset_count}, m_count);
    end
  endtask

  initial begin
    rst = 1'b1;
    sif.pll_locked = 1'b1;
    sif.tact_n = 1'b1;
    sif.plug_resn = 1'b1;
    model_reset();

    // Power-on reset with PLL already locked
    rst_in = 1'b1; tick(3);
    chk("por_resn", {31'd0, sif.resn}, 0);
    chk("por_count", {24'd0, sif.reset_count}, 0);
    rst_in = 1'b0; tick(10);
    chk("por_up", {31'd0, sif.resn}, 1);
    chk("por_count1", {24'd0, sif.reset_count}, 1);
    chk("por_cause", {30'd0, sif.reset_cause}, 0);

    // Bouncing switch never settles long enough
    for (int i = 0; i < 40; i++) begin
      tact_in = ((i / 3) % 2) == 0;
      tick(1);
    end
    tact_in = 1'b1; tick(15);
    chk("bounce_resn", {31'd0, sif.resn}, 1);
    tact_in = 1'b0; tick(20);
    chk("tact_low", {31'd0, sif.resn}, 0);
    chk("tact_cause", {30'd0, sif.reset_cause}, 2);
    tact_in = 1'b1; tick(25);
    chk("tact_up", {31'd0, sif.resn}, 1);
    chk("tact_count", {24'd0, sif.reset_count}, 2);

    // Plug glitch then real request
    plug_in = 1'b0; tick(1);
    plug_in = 1'b1; tick(10);
    chk("glitch_count", {24'd0, sif.reset_count}, 2);
    plug_in = 1'b0; tick(3);
    plug_in = 1'b1; tick(15);
    chk("plug_cause", {30'd0, sif.reset_cause}, 3);
    chk("plug_count", {24'd0, sif.reset_count}, 3);

    // Lock loss from run
    pll_in = 1'b0; tick(3);
    chk("lock_resn", {31'd0, sif.resn}, 0);
    chk("lock_cause", {30'd0, sif.reset_cause}, 1);
    tick(2);
    pll_in = 1'b1; tick(15);
    chk("relock_up", {31'd0, sif.resn}, 1);
    chk("relock_count", {24'd0, sif.reset_count}, 4);

    // Lock loss and plug request together
    pll_in = 1'b0; plug_in = 1'b0; tick(5);
    chk("simul_cause", {30'd0, sif.reset_cause}, 1);
    pll_in = 1'b1; plug_in = 1'b1; tick(20);

    // Saturating count
    for (int i = 0; i < 300; i++) begin
      plug_in = 1'b0; tick(3);
      plug_in = 1'b1; tick(12);
    end
    chk("sat_count", {24'd0, sif.reset_count}, 255);
    chk("sat_resn", {31'd0, sif.resn}, 1);

    // Reset while holding
    tact_in = 1'b0; tick(15);
    rst_in = 1'b1; tick(1);
    chk("rst_hold_count", {24'd0, sif.reset_count}, 0);
    chk("rst_hold_cause", {30'd0, sif.reset_cause}, 0);
    chk("rst_hold_resn", {31'd0, sif.resn}, 0);
    rst_in = 1'b0; tact_in = 1'b1; tick(20);

    // Random segments
    for (int s = 0; s < 150; s++) begin
      int kind, len;
      kind = $urandom_range(0, 9);
      case (kind)
        0, 1: begin len = $urandom_range(1, 30); tick(len); end
        2, 3: begin len = $urandom_range(1, 25); tact_in = 1'b0; tick(len); end
        4, 5: begin len = $urandom_range(1, 5); plug_in = 1'b0; tick(len); end
        6: begin len = $urandom_range(1, 6); pll_in = 1'b0; tick(len); end
        7, 8: begin
          len = $urandom_range(5, 30);
          for (int j = 0; j < len; j++) begin
            tact_in = $urandom_range(0, 1) != 0;
            plug_in = $urandom_range(0, 3) != 0;
            tick(1);
          end
        end
        default: begin len = $urandom_range(1, 3); rst_in = 1'b1; tick(len); end
      endcase
      rst_in = 1'b0; pll_in = 1'b1; tact_in = 1'b1; plug_in = 1'b1;
      tick($urandom_range(0, 12));
    end
    tick(30);
    chk("final_up", {31'd0, sif.resn}, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
